pipelined_barrel_shifter: RTL and testbench

//   Multi-mode barrel shifter, pipelined one mux level per stage, with valid/ready flow control.

---
 rtl/pipelined_barrel_shifter.sv | 127 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter with one mux level per pipeline stage and valid/ready flow control.
// Stage i applies a shift of 2**i when amount bit i is set; the last stage register drives Out.
module pipelined_barrel_shifter #(
   parameter int DATAWIDTH = 32
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic [DATAWIDTH-1:0]         In,
   input  logic [$clog2(DATAWIDTH)-1:0] ShiftAmount,
   input  logic                         ShiftIn,
   input  logic [1:0]                   Mode,
   input  logic                         InValid,
   output logic                         InReady,
   output logic [DATAWIDTH-1:0]         Out,
   output logic                         OutValid,
   input  logic                         OutReady
);

   localparam int muxNum = $clog2(DATAWIDTH);

   localparam logic [1:0] ModeShl = 2'b00;
   localparam logic [1:0] ModeShr = 2'b01;
   localparam logic [1:0] ModeSra = 2'b10;

   // Per-stage registers; index muxNum-1 is the output stage.
   logic [muxNum-1:0][DATAWIDTH-1:0] data_q;
   logic [muxNum-1:0][muxNum-1:0]    amt_q;
   logic [muxNum-1:0][1:0]           mode_q;
   logic [muxNum-1:0]                fill_q;
   logic [muxNum-1:0]                valid_q;

   // Values presented to each stage's input and that stage's shifted result.
   logic [muxNum-1:0][DATAWIDTH-1:0] src_data;
   logic [muxNum-1:0][muxNum-1:0]    src_amt;
   logic [muxNum-1:0][1:0]           src_mode;
   logic [muxNum-1:0]                src_fill;
   logic [muxNum-1:0]                src_valid;
   logic [muxNum-1:0][DATAWIDTH-1:0] res;
   logic [muxNum-1:0]                ready;

   function automatic logic [DATAWIDTH-1:0] stage_shift(
      input logic [DATAWIDTH-1:0] d,
      input logic                 en,
      input logic [1:0]           mode,
      input logic                 fill,
      input int                   s
   );
      logic [DATAWIDTH-1:0] lo_mask;
      logic [DATAWIDTH-1:0] hi_mask;
      logic [DATAWIDTH-1:0] r;
      lo_mask = ~({DATAWIDTH{1'b1}} << s);
      hi_mask = ~({DATAWIDTH{1'b1}} >> s);
      case (mode)
         ModeShl: r = (d << s) | (lo_mask & {DATAWIDTH{fill}});
         ModeShr: r = (d >> s) | (hi_mask & {DATAWIDTH{fill}});
         ModeSra: r = (d >> s) | (hi_mask & {DATAWIDTH{d[DATAWIDTH-1]}});
         default: r = (d << s) | (d >> (DATAWIDTH - s));
      endcase
      return en ? r : d;
   endfunction

   always_comb begin
      src_data  = '0;
      src_amt   = '0;
      src_mode  = '0;
      src_fill  = '0;
      src_valid = '0;
      res       = '0;
      ready     = '0;

      // A stage can load when empty or when its occupant moves on this cycle,
      // so bubbles collapse and a full pipe still streams at one item per clock.
      ready[muxNum-1] = !valid_q[muxNum-1] || OutReady;
      for (int k = muxNum - 2; k >= 0; k--) begin
         ready[k] = !valid_q[k] || ready[k+1];
      end

      src_data[0]  = In;
      src_amt[0]   = ShiftAmount;
      src_mode[0]  = Mode;
      src_fill[0]  = ShiftIn;
      src_valid[0] = InValid;
      for (int k = 1; k < muxNum; k++) begin
         src_data[k]  = data_q[k-1];
         src_amt[k]   = amt_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_fill[k]  = fill_q[k-1];
         src_valid[k] = valid_q[k-1];
      end

      for (int k = 0; k < muxNum; k++) begin
         res[k] = stage_shift(src_data[k], src_amt[k][k], src_mode[k], src_fill[k], 1 << k);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         data_q  <= '0;
         amt_q   <= '0;
         mode_q  <= '0;
         fill_q  <= '0;
         valid_q <= '0;
      end else begin
         for (int k = 0; k < muxNum; k++) begin
            if (ready[k]) begin
               valid_q[k] <= src_valid[k];
               // Payload only moves with a valid item so Out stays put across bubbles.
               if (src_valid[k]) begin
                  data_q[k] <= res[k];
                  amt_q[k]  <= src_amt[k];
                  mode_q[k] <= src_mode[k];
                  fill_q[k] <= src_fill[k];
               end
            end
         end
      end
   end

   // Output-stage side-band and already-consumed amount bits have no reader.
   logic unused_sideband;
   assign unused_sideband = ^{amt_q, mode_q, fill_q};

   assign InReady  = ready[0];
   assign Out      = data_q[muxNum-1];
   assign OutValid = valid_q[muxNum-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at DATAWIDTH=8 (three stages).
module tb_pipelined_barrel_shifter;

   localparam int W = 8;
   localparam int M = 3;

   logic         Clock = 1'b0;
   logic         Reset;
   logic [W-1:0] In;
   logic [M-1:0] ShiftAmount;
   logic         ShiftIn;
   logic [1:0]   Mode;
   logic         InValid;
   logic         InReady;
   logic [W-1:0] Out;
   logic         OutValid;
   logic         OutReady;

   pipelined_barrel_shifter #(.DATAWIDTH(W)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .In          (In),
      .ShiftAmount (ShiftAmount),
      .ShiftIn     (ShiftIn),
      .Mode        (Mode),
      .InValid     (InValid),
      .InReady     (InReady),
      .Out         (Out),
      .OutValid    (OutValid),
      .OutReady    (OutReady)
   );

   always #5 Clock = ~Clock;

   logic [W-1:0] sb_q[$];
   int chk_cnt  = 0;
   int err_cnt  = 0;
   int xfer_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [M-1:0] a,
                                          input logic [1:0] m, input logic f);
      logic [W-1:0] r;
      int s;
      s = int'(a);
      for (int j = 0; j < W; j++) begin
         case (m)
            2'b00:   r[j] = (j >= s) ? d[j-s] : f;
            2'b01:   r[j] = (j + s < W) ? d[j+s] : f;
            2'b10:   r[j] = (j + s < W) ? d[j+s] : d[W-1];
            default: r[j] = d[(j - s + W) % W];
         endcase
      end
      return r;
   endfunction

   // Scoreboard: push on accepted input, pop and compare on output transfer.
   always @(negedge Clock) begin
      if (!Reset) begin
         if (InValid && InReady) sb_q.push_back(model(In, ShiftAmount, Mode, ShiftIn));
         if (OutValid && OutReady) begin
            xfer_cnt++;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("result", 32'(Out), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [M-1:0] a, input logic [1:0] m,
                       input logic f, output int waits);
      In = d; ShiftAmount = a; Mode = m; ShiftIn = f; InValid = 1'b1;
      waits = 0;
      forever begin
         @(negedge Clock);
         if (InReady) break;
         waits++;
         if (waits > 50) begin
            check("send_timeout", 32'(waits), 32'd0);
            break;
         end
      end
      @(posedge Clock); #1;
      InValid = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [W-1:0] d, input logic [M-1:0] a,
                           input logic [1:0] m, input logic f, input logic [W-1:0] exp);
      int w;
      int c;
      send(d, a, m, f, w);
      c = 0;
      while (c < 10) begin
         @(negedge Clock);
         c++;
         if (OutValid) break;
      end
      check({tag, "_lat"}, 32'(c), 32'(M));
      check(tag, 32'(Out), 32'(exp));
      @(posedge Clock); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] stall_in [5];
      int acc;
      int base;
      int w;
      int stalls;

      In = '0; ShiftAmount = '0; Mode = '0; ShiftIn = 1'b0; InValid = 1'b0;
      OutReady = 1'b1; Reset = 1'b1;
      #1;
      check("rst_in_ready", 32'(InReady), 32'd1);
      check("rst_out_valid", 32'(OutValid), 32'd0);
      repeat (2) @(posedge Clock);
      #1;
      check("rst_out", 32'(Out), 32'd0);
      check("rst_in_ready_held", 32'(InReady), 32'd1);
      @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock); #1;

      directed("shl_fill1", 8'b1001_0110, 3'd3, 2'b00, 1'b1, 8'b1011_0111);
      directed("shr_fill0", 8'b1001_0110, 3'd2, 2'b01, 1'b0, 8'b0010_0101);
      directed("sra",       8'b1001_0110, 3'd2, 2'b10, 1'b0, 8'b1110_0101);
      directed("rol",       8'b1001_0110, 3'd3, 2'b11, 1'b0, 8'b1011_0100);
      for (int m = 0; m < 4; m++) directed("amt0", 8'hA5, 3'd0, 2'(m), 1'b1, 8'hA5);
      directed("sra_max",   8'h80, 3'd7, 2'b10, 1'b0, 8'hFF);

      // Stall: five items offered with OutReady low, only three fit.
      stall_in[0] = 8'h3C; stall_in[1] = 8'hC3; stall_in[2] = 8'h5A;
      stall_in[3] = 8'h81; stall_in[4] = 8'h7E;
      OutReady = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         if (acc < 5) begin
            In = stall_in[acc]; ShiftAmount = 3'(acc + 1); Mode = 2'(acc); ShiftIn = acc[0];
            InValid = 1'b1;
         end
         @(negedge Clock);
         if (InValid && InReady) acc++;
         @(posedge Clock); #1;
      end
      InValid = 1'b0;
      check("stall_accepts", 32'(acc), 32'd3);
      check("stall_in_ready", 32'(InReady), 32'd0);
      check("stall_out_valid", 32'(OutValid), 32'd1);
      check("stall_out", 32'(Out), 32'(model(stall_in[0], 3'd1, 2'd0, 1'b0)));
      base = xfer_cnt;
      OutReady = 1'b1;
      for (int i = acc; i < 5; i++) send(stall_in[i], 3'(i + 1), 2'(i), i[0], w);
      repeat (3) @(posedge Clock);
      #1;
      check("no_gap", 32'(xfer_cnt - base), 32'd5);
      check("stall_drained", 32'(sb_q.size()), 32'd0);

      // Back-to-back random traffic with downstream always ready.
      base = xfer_cnt;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         send(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), w);
         stalls += w;
      end
      for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(posedge Clock);
      #1;
      check("b2b_stalls", 32'(stalls), 32'd0);
      check("b2b_count", 32'(xfer_cnt - base), 32'd200);
      check("b2b_drained", 32'(sb_q.size()), 32'd0);

      // Reset with three items in flight.
      for (int i = 0; i < 3; i++) send(8'(8'h11 * (i + 1)), 3'(i + 2), 2'(i), 1'b1, w);
      check("pre_rst_out_valid", 32'(OutValid), 32'd1);
      Reset = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(OutValid), 32'd0);
      check("mid_rst_out", 32'(Out), 32'd0);
      check("mid_rst_in_ready", 32'(InReady), 32'd1);
      sb_q.delete();
      base = xfer_cnt;
      @(posedge Clock); #3;
      Reset = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      check("no_stale_out", 32'(xfer_cnt - base), 32'd0);
      directed("post_rst", 8'h3C, 3'd5, 2'b11, 1'b0, model(8'h3C, 3'd5, 2'b11, 1'b0));
      check("final_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
